// File: rtl/stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stream_fifo_pkg
//   Shared types for the stream FIFO slice.
//   std_clock_info_t : clock-domain descriptor handed down to every register
//                      stage so each one can sanity-check the clock it runs on.
// -----------------------------------------------------------------------------
package stream_fifo_pkg;

  typedef struct packed {
    logic [15:0] freq_mhz;     // nominal frequency, informational
    logic        async_reset;  // 1 = domain uses an asynchronous reset
  } std_clock_info_t;

endpackage

// File: rtl/stream_fifo_if.sv
// -----------------------------------------------------------------------------
// stream_intf
//   Valid/ready stream with a WIDTH-bit payload.
//   modport in  : consumer view (receives valid/payload, drives ready)
//   modport out : producer view (drives valid/payload, receives ready)
// -----------------------------------------------------------------------------
interface stream_intf #(
  parameter int unsigned WIDTH = 1
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] payload;

  modport in  (input  valid, input  payload, output ready);
  modport out (output valid, output payload, input  ready);

endinterface

// File: rtl/stream_fifo_pointer.sv
// -----------------------------------------------------------------------------
// stream_fifo_pointer
//   Wrap-around index into a DEPTH-entry ring buffer. DEPTH need not be a
//   power of two, so the wrap is an explicit compare against DEPTH-1.
//   Ports:
//     clk     : clock
//     rst     : synchronous active-high reset, returns ptr to 0
//     advance : step the pointer by one this cycle
//     ptr     : current index, 0..DEPTH-1
// -----------------------------------------------------------------------------
module stream_fifo_pointer
  import stream_fifo_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = '0,
  parameter int unsigned     DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // The reset below is sampled on the clock edge; an async-reset domain
  // would need a different register style.
  if (CLOCK_INFO.async_reset) begin : g_bad_clock
    $error("stream_fifo_pointer: clock domain declares an asynchronous reset");
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
    if (cur == PTR_W'(DEPTH - 1)) return '0;
    return cur + PTR_W'(1);
  endfunction

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr(ptr);
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//   First-word-fall-through FIFO between two valid/ready streams. All flags
//   and stream_in.ready come straight from registers, so there is no
//   combinational path from stream_out.ready back to stream_in.ready. The
//   cost: a full FIFO refuses a push even in a cycle where it is popped.
//   Ports:
//     clk        : clock
//     rst        : synchronous active-high reset; discards all stored words
//     stream_in  : write side (push = valid & ready)
//     stream_out : read side  (pop  = valid & ready), payload = head entry
//     count      : registered occupancy, 0..DEPTH
//     full       : registered, count == DEPTH
//     empty      : registered, count == 0
// -----------------------------------------------------------------------------
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter int unsigned     DEPTH      = 4,
  parameter type             T          = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  stream_intf.in                     stream_in,
  stream_intf.out                    stream_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be within 2..1024");
  end

  if ($bits(T) != $bits(stream_in.payload) ||
      $bits(T) != $bits(stream_out.payload)) begin : g_bad_width
    $error("stream_fifo: payload type width does not match the stream interfaces");
  end

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;
  logic             full_next;

  assign push = stream_in.valid & ready_q;
  assign pop  = stream_out.valid & stream_out.ready;

  assign stream_in.ready    = ready_q;
  assign stream_out.valid   = ~empty;
  assign stream_out.payload = mem[rd_ptr];

  stream_fifo_pointer #(
    .CLOCK_INFO (CLOCK_INFO),
    .DEPTH      (DEPTH)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (push),
    .ptr     (wr_ptr)
  );

  stream_fifo_pointer #(
    .CLOCK_INFO (CLOCK_INFO),
    .DEPTH      (DEPTH)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (pop),
    .ptr     (rd_ptr)
  );

  // NOTE: count_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  assign full_next = (count_next == CNT_W'(DEPTH));

  // NOTE: storage has no reset; occupancy is tracked by count/pointers, and
  // leaving the array unreset lets it map onto RAM or plain flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= stream_in.payload;
    end
  end

  // ready is its own register rather than ~full so it can be held low
  // throughout reset while full itself resets to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      full    <= full_next;
      empty   <= (count_next == '0);
      ready_q <= ~full_next;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//   Bench for stream_fifo with two instances: DEPTH=4 and DEPTH=3. Each has a
//   scoreboard queue filled from accepted input words and drained by a monitor
//   that compares every output transfer. Directed sequences add explicit
//   checks of flags, counts and hand-computed payloads.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count4;
  logic       full4;
  logic       empty4;
  logic [1:0] count3;
  logic       full3;
  logic       empty3;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q4[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  stream_intf #(.WIDTH(8)) in4  ();
  stream_intf #(.WIDTH(8)) out4 ();
  stream_intf #(.WIDTH(8)) in3  ();
  stream_intf #(.WIDTH(8)) out3 ();

  stream_fifo #(.DEPTH(4), .T(logic [7:0])) dut4 (
    .clk        (clk),
    .rst        (rst),
    .stream_in  (in4),
    .stream_out (out4),
    .count      (count4),
    .full       (full4),
    .empty      (empty4)
  );

  stream_fifo #(.DEPTH(3), .T(logic [7:0])) dut3 (
    .clk        (clk),
    .rst        (rst),
    .stream_in  (in3),
    .stream_out (out3),
    .count      (count3),
    .full       (full3),
    .empty      (empty3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each output transfer first, then record the accepted
  // input word, so a same-cycle bypass would be caught as a mismatch.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (out4.valid === 1'b1 && out4.ready === 1'b1) begin
        if (q4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb4_unexpected: got %0h expected no output", out4.payload);
        end else begin
          check("sb4_order", 32'(out4.payload), 32'(q4.pop_front()));
        end
      end
      if (in4.valid === 1'b1 && in4.ready === 1'b1) q4.push_back(in4.payload);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
    end else begin
      if (out3.valid === 1'b1 && out3.ready === 1'b1) begin
        if (q3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb3_unexpected: got %0h expected no output", out3.payload);
        end else begin
          check("sb3_order", 32'(out3.payload), 32'(q3.pop_front()));
        end
      end
      if (in3.valid === 1'b1 && in3.ready === 1'b1) q3.push_back(in3.payload);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] data;
    rst          = 1'b1;
    in4.valid    = 1'b0;
    in4.payload  = '0;
    out4.ready   = 1'b0;
    in3.valid    = 1'b0;
    in3.payload  = '0;
    out3.ready   = 1'b0;

    // ---- reset / idle ------------------------------------------------------
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_ready4", 32'(in4.ready), 0);
    check("rst_ready3", 32'(in3.ready), 0);
    check("rst_valid4", 32'(out4.valid), 0);
    next_cycle();                       // third reset edge has now passed
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("idle_ready", 32'(in4.ready), 1);
    check("idle_valid", 32'(out4.valid), 0);
    check("idle_count", 32'(count4), 0);
    check("idle_empty", 32'(empty4), 1);
    check("idle_full", 32'(full4), 0);
    check("idle_empty3", 32'(empty3), 1);

    // ---- single word ------------------------------------------------------
    next_cycle();
    in4.valid   = 1'b1;
    in4.payload = 8'hA5;
    next_cycle();
    in4.valid   = 1'b0;
    @(negedge clk);
    check("single_valid", 32'(out4.valid), 1);
    check("single_payload", 32'(out4.payload), 32'h A5);
    check("single_count", 32'(count4), 1);
    next_cycle();
    out4.ready = 1'b1;
    next_cycle();
    out4.ready = 1'b0;
    @(negedge clk);
    check("single_empty", 32'(empty4), 1);
    check("single_valid_off", 32'(out4.valid), 0);

    // ---- fill and stall ---------------------------------------------------
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      in4.valid   = 1'b1;
      in4.payload = 8'(i);
      next_cycle();
    end
    in4.payload = 8'h05;                // fifth word offered and held
    @(negedge clk);
    check("fill_full", 32'(full4), 1);
    check("fill_ready", 32'(in4.ready), 0);
    check("fill_count", 32'(count4), 4);
    check("fill_head", 32'(out4.payload), 1);
    next_cycle();
    @(negedge clk);
    check("stall_count", 32'(count4), 4);

    // ---- full with simultaneous pop ---------------------------------------
    next_cycle();
    out4.ready = 1'b1;
    next_cycle();
    out4.ready = 1'b0;
    @(negedge clk);
    check("fullpop_count", 32'(count4), 3);
    check("fullpop_full", 32'(full4), 0);
    check("fullpop_ready", 32'(in4.ready), 1);
    next_cycle();
    in4.valid = 1'b0;
    @(negedge clk);
    check("refill_count", 32'(count4), 4);
    check("refill_full", 32'(full4), 1);
    check("refill_head", 32'(out4.payload), 2);

    // drain: monitor expects 2,3,4,5
    next_cycle();
    out4.ready = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    out4.ready = 1'b0;
    @(negedge clk);
    check("drain_empty", 32'(empty4), 1);
    check("drain_count", 32'(count4), 0);

    // ---- throughput and wrap, DEPTH=3 -------------------------------------
    next_cycle();
    out3.ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      in3.valid   = (i < 10);
      in3.payload = 8'(i);
      @(negedge clk);
      if (i < 10) check("tput_ready", 32'(in3.ready), 1);
      if (i > 0) begin
        check("tput_valid", 32'(out3.valid), 1);
        check("tput_payload", 32'(out3.payload), 32'(i - 1));
      end
      next_cycle();
    end
    in3.valid  = 1'b0;
    out3.ready = 1'b0;
    @(negedge clk);
    check("tput_empty", 32'(empty3), 1);

    // ---- randomised back-pressure on DEPTH=4 ------------------------------
    next_cycle();
    data = 8'h10;
    for (int i = 0; i < 80; i++) begin
      in4.valid   = ($urandom_range(0, 3) != 0);
      in4.payload = data;
      out4.ready  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check("rand_flags_excl", 32'(full4 & empty4), 0);
      check("rand_count_le_depth", 32'(count4 <= 3'd4), 1);
      if (in4.valid && in4.ready) data = data + 8'd1;
      next_cycle();
    end

    // drain with a bounded wait
    in4.valid  = 1'b0;
    out4.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (empty4) break;
      next_cycle();
    end
    check("rand_drain_empty", 32'(empty4), 1);

    // ---- mid-stream reset with two words stored ---------------------------
    next_cycle();
    out4.ready  = 1'b0;
    in4.valid   = 1'b1;
    in4.payload = 8'h77;
    next_cycle();
    in4.payload = 8'h88;
    next_cycle();
    in4.valid = 1'b0;
    @(negedge clk);
    check("prerst_count", 32'(count4), 2);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(count4), 0);
    check("midrst_valid", 32'(out4.valid), 0);
    check("midrst_empty", 32'(empty4), 1);
    next_cycle();
    out4.ready  = 1'b1;
    in4.valid   = 1'b1;
    in4.payload = 8'h99;
    next_cycle();
    in4.valid = 1'b0;
    @(negedge clk);
    check("postrst_valid", 32'(out4.valid), 1);
    check("postrst_payload", 32'(out4.payload), 32'h99);
    next_cycle();
    out4.ready = 1'b0;
    @(negedge clk);
    check("postrst_empty", 32'(empty4), 1);

    check("sb4_leftover", 32'(q4.size()), 0);
    check("sb3_leftover", 32'(q3.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous first-word-fall-through FIFO on the stream valid/ready interface.
- Sits downstream of a registered stream stage chain and absorbs bursts, so a stalling consumer does not back-pressure the pipeline for up to DEPTH transfers.
- Decouples stream_in.ready from stream_out.ready: no combinational ready path through the block.

Parameters:
- CLOCK_INFO, 'b0, std_clock_info_t clock descriptor, passed through to registers.
- DEPTH, 4, number of entries; legal range 2..1024; need not be a power of two.
- T, logic, payload type; $bits(T) must equal the payload width of both interfaces (static assert).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stream_in  stream_intf.in  valid/ready/payload(T)  write side.
- stream_out  stream_intf.out  valid/ready/payload(T)  read side.
- count  output  $clog2(DEPTH+1)  current occupancy, registered.
- full  output  1  count == DEPTH, registered.
- empty  output  1  count == 0, registered.

Behaviour:
- Interface timing: one clock (clk); reset is synchronous and active-high (rst).
- Reset state: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, stream_out.valid=0. Storage contents are not reset.
- While rst is high, stream_in.ready=0. Ready is 1 in the first cycle after rst deasserts.
- Push = stream_in.valid & stream_in.ready. Pop = stream_out.valid & stream_out.ready.
- stream_in.ready = !full, driven from registers only; it does not depend on stream_out.ready.
- stream_out.valid = !empty.
- stream_out.payload = mem[rd_ptr], read combinationally. It is stable while valid is high and ready is low.
- Latency: a word pushed in cycle N is visible (valid=1) in cycle N+1 if the FIFO was empty. There is no bypass: the same-cycle in-to-out path is forbidden.
- Push only: mem[wr_ptr] <= payload; wr_ptr advances; count+1.
- Pop only: rd_ptr advances; count-1.
- Push and pop in the same cycle: both pointers advance; count unchanged.
- When full, push cannot occur even if a pop happens that cycle. This is the deliberate price of no combinational ready path.
- Pointer wrap: a pointer at DEPTH-1 goes to 0 by explicit compare, not modulo power of two. Pointer width is $clog2(DEPTH).
- full and empty are computed from the next count and registered. They are never both 1.
- Order is strictly preserved; no word is dropped or duplicated.
- Reset mid-operation: all stored words are discarded; the next cycle matches the reset state.
- The payload value is don't-care when valid is low.

Decomposition:
- stream_pkg: no new typedefs. A local function for pointer increment-with-wrap stays in the module.
- Sub-module stream_fifo_pointer: parameterised DEPTH, inputs clk/rst/advance, output ptr. It holds the wrap-around counter and is instantiated twice (write and read).
- Storage is an inferred array of T in the top module.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release → ready=1, valid=0, count=0, empty=1, full=0. With rst high: ready=0.
- Single word, DEPTH=4: push 0xA5 at cycle N with out.ready=0 → valid=1 and payload=0xA5 at N+1, count=1. Raise out.ready → pop; empty=1 on the following cycle.
- Fill and stall, DEPTH=4: push 0x1..0x4 with out.ready=0 → after the 4th push full=1, ready=0, count=4. A 5th offered word (0x5) is not accepted and is held by the source. Then drain → outputs 0x1,0x2,0x3,0x4 in order, then 0x5 after re-accept.
- Full with simultaneous pop: full, in.valid=1, out.ready=1 → pop occurs, no push that cycle, count=3. Next cycle the push occurs and count returns to 4.
- Throughput and wrap, DEPTH=3 (non-power-of-two): continuous valid/ready for 10 words 0..9 → one transfer per cycle after 1-cycle fill, outputs 0..9 in order, pointers wrap 2→0 without error.
- Randomised back-pressure plus mid-stream reset: scoreboard against a reference queue. Assert rst with count=2 → next cycle count=0, valid=0, and pre-reset words never appear at the output.
